// File: rtl/qam16_slicer_demapper_if.sv
// Symbol bus between the matched-filter front end and the 16-QAM slicer/demapper.
// master drives the samples and strobe; slave returns decisions and the threshold.
interface qam16_slicer_demapper_if;
    localparam int unsigned DW = 18;

    logic                 sym_clk_en;
    logic signed [DW-1:0] in_phs_in;
    logic signed [DW-1:0] quad_in;
    logic [3:0]           sym_out;
    logic                 sym_valid;
    logic signed [DW-1:0] in_phs_dec;
    logic signed [DW-1:0] quad_dec;
    logic signed [DW-1:0] ref_level;
    logic                 ref_update;

    modport master (
        output sym_clk_en, in_phs_in, quad_in,
        input  sym_out, sym_valid, in_phs_dec, quad_dec, ref_level, ref_update
    );

    modport slave (
        input  sym_clk_en, in_phs_in, quad_in,
        output sym_out, sym_valid, in_phs_dec, quad_dec, ref_level, ref_update
    );
endinterface

// File: rtl/qam16_slicer_demapper.sv
// 16-QAM slicer and Gray demapper with a block-averaged decision threshold.
// Two-stage pipeline: sign/|x| capture, then threshold compare and level decision.
module qam16_slicer_demapper #(
    parameter int unsigned        LOG2_AVG = 12,
    parameter logic signed [17:0] INIT_REF = 18'sd32768
) (
    input  logic                          clk,
    input  logic                          reset,
    qam16_slicer_demapper_if.slave        bus
);
    localparam int unsigned DW = 18;
    localparam int unsigned AW = 19 + LOG2_AVG;
    localparam logic signed [DW-1:0] X_MIN   = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW:0]   SAT_POS = (DW+1)'((1 << (DW-1)) - 1);
    localparam logic signed [DW:0]   SAT_NEG = -SAT_POS;

    typedef enum logic {FILL, RUN} est_state_t;

    // |x| with the single unrepresentable magnitude clamped to full scale
    function automatic logic [DW-2:0] abs_sat(input logic signed [DW-1:0] x);
        if (x == X_MIN)
            return '1;
        else if (x[DW-1])
            return (DW-1)'(-x);
        else
            return (DW-1)'(x);
    endfunction

    logic                 s1_valid;
    logic                 s1_neg_i;
    logic                 s1_neg_q;
    logic [DW-2:0]        s1_abs_i;
    logic [DW-2:0]        s1_abs_q;

    logic [AW-1:0]        acc;
    logic [LOG2_AVG-1:0]  sym_cnt;
    est_state_t           est_state;

    logic signed [DW-1:0] ref_half_c;
    logic signed [DW:0]   outer_sum_c;
    logic signed [DW-1:0] outer_lvl_c;
    logic                 outer_i_c;
    logic                 outer_q_c;
    logic signed [DW-1:0] lvl_i_c;
    logic signed [DW-1:0] lvl_q_c;
    logic signed [DW-1:0] dec_i_c;
    logic signed [DW-1:0] dec_q_c;
    logic [DW-1:0]        sym_sum_c;
    logic [AW-1:0]        acc_next_c;
    logic                 wrap_c;

    // Decision levels and estimator arithmetic from the current threshold
    always_comb begin
        ref_half_c  = bus.ref_level >>> 1;
        outer_sum_c = (DW+1)'(bus.ref_level) + (DW+1)'(ref_half_c);
        if (outer_sum_c > SAT_POS)
            outer_lvl_c = DW'(SAT_POS);
        else if (outer_sum_c < SAT_NEG)
            outer_lvl_c = DW'(SAT_NEG);
        else
            outer_lvl_c = DW'(outer_sum_c);

        outer_i_c = $signed({1'b0, s1_abs_i}) >= bus.ref_level;
        outer_q_c = $signed({1'b0, s1_abs_q}) >= bus.ref_level;
        lvl_i_c   = outer_i_c ? outer_lvl_c : ref_half_c;
        lvl_q_c   = outer_q_c ? outer_lvl_c : ref_half_c;
        dec_i_c   = s1_neg_i ? -lvl_i_c : lvl_i_c;
        dec_q_c   = s1_neg_q ? -lvl_q_c : lvl_q_c;

        sym_sum_c  = DW'(s1_abs_i) + DW'(s1_abs_q);
        acc_next_c = acc + AW'(sym_sum_c);
        wrap_c     = s1_valid && (sym_cnt == '1);
    end

    // Stage 1: sign and saturated magnitude at the decision instant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_neg_i <= 1'b0;
            s1_neg_q <= 1'b0;
            s1_abs_i <= '0;
            s1_abs_q <= '0;
        end else begin
            s1_valid <= bus.sym_clk_en;
            if (bus.sym_clk_en) begin
                s1_neg_i <= bus.in_phs_in[DW-1];
                s1_neg_q <= bus.quad_in[DW-1];
                s1_abs_i <= abs_sat(bus.in_phs_in);
                s1_abs_q <= abs_sat(bus.quad_in);
            end
        end
    end

    // Stage 2: Gray code is {positive, inner} per axis
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.sym_out    <= '0;
            bus.sym_valid  <= 1'b0;
            bus.in_phs_dec <= '0;
            bus.quad_dec   <= '0;
        end else begin
            bus.sym_valid <= s1_valid;
            if (s1_valid) begin
                bus.sym_out    <= {~s1_neg_i, ~outer_i_c, ~s1_neg_q, ~outer_q_c};
                bus.in_phs_dec <= dec_i_c;
                bus.quad_dec   <= dec_q_c;
            end
        end
    end

    // Reference estimator: mean of (|I|+|Q|)/2 over 2^LOG2_AVG symbols
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            est_state      <= FILL;
            acc            <= '0;
            sym_cnt        <= '0;
            bus.ref_level  <= INIT_REF;
            bus.ref_update <= 1'b0;
        end else begin
            bus.ref_update <= wrap_c;
            if (s1_valid) begin
                sym_cnt <= sym_cnt + LOG2_AVG'(1);
                if (wrap_c) begin
                    acc           <= '0;
                    bus.ref_level <= DW'(acc_next_c >> (LOG2_AVG + 1));
                    if (est_state == FILL)
                        est_state <= RUN;
                end else begin
                    acc <= acc_next_c;
                end
            end
        end
    end
endmodule

// File: tb/tb_qam16_slicer_demapper.sv
// Directed bench for qam16_slicer_demapper with a 4-symbol estimate window.
module tb_qam16_slicer_demapper;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    qam16_slicer_demapper_if bus ();

    qam16_slicer_demapper #(
        .LOG2_AVG (2),
        .INIT_REF (18'sd32768)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Idle cycles carry junk samples that must be ignored
    task automatic drive_idle;
        bus.sym_clk_en = 1'b0;
        bus.in_phs_in  = 18'($urandom);
        bus.quad_in    = 18'($urandom);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Ends on the negedge after the strobe cycle; result appears one negedge later
    task automatic send(input logic signed [17:0] i, input logic signed [17:0] q);
        @(negedge clk);
        bus.sym_clk_en = 1'b1;
        bus.in_phs_in  = i;
        bus.quad_in    = q;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset;
        reset = 1'b0;
        @(negedge clk);
        bus.sym_clk_en = 1'b1;
        bus.in_phs_in  = 18'sd49152;
        bus.quad_in    = -18'sd49152;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if ({bus.sym_valid, bus.ref_update} !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_pulse cyc%0d got valid=%b upd=%b exp 0 0", c, bus.sym_valid, bus.ref_update);
            end
        end
        n_vec++;
        if ({bus.sym_out, bus.in_phs_dec, bus.quad_dec} !== 40'd0) begin
            n_bad++;
            $display("FAIL reset_outs got sym=%b i=%0d q=%0d exp 0 0 0", bus.sym_out, bus.in_phs_dec, bus.quad_dec);
        end
        n_vec++;
        if (bus.ref_level !== 18'sd32768) begin
            n_bad++;
            $display("FAIL reset_ref got %0d exp 32768", bus.ref_level);
        end
        drive_idle();
        reset = 1'b1;
    endtask

    task automatic test_mapping;
        do_reset();
        send(18'sd49152, -18'sd16384);
        n_vec++;
        if (bus.sym_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL map_early got valid=%b exp 0", bus.sym_valid);
        end
        @(negedge clk);
        n_vec++;
        if ({bus.sym_out, bus.in_phs_dec, bus.quad_dec, bus.sym_valid} !== {4'b1001, 18'sd49152, -18'sd16384, 1'b1}) begin
            n_bad++;
            $display("FAIL map got sym=%b i=%0d q=%0d v=%b exp 1001 49152 -16384 1",
                     bus.sym_out, bus.in_phs_dec, bus.quad_dec, bus.sym_valid);
        end
        @(negedge clk);
        n_vec++;
        if ({bus.sym_out, bus.in_phs_dec, bus.quad_dec, bus.sym_valid} !== {4'b1001, 18'sd49152, -18'sd16384, 1'b0}) begin
            n_bad++;
            $display("FAIL map_hold got sym=%b i=%0d q=%0d v=%b exp 1001 49152 -16384 0",
                     bus.sym_out, bus.in_phs_dec, bus.quad_dec, bus.sym_valid);
        end
    endtask

    task automatic test_ties_and_sat;
        logic signed [17:0] vi [3] = '{18'sd32768, -18'sd32768, -18'sd131072};
        logic signed [17:0] vq [3] = '{18'sd0, 18'sd16384, 18'sd131071};
        logic [3:0]         es [3] = '{4'b1011, 4'b0011, 4'b0010};
        logic signed [17:0] ei [3] = '{18'sd49152, -18'sd49152, -18'sd49152};
        logic signed [17:0] eq [3] = '{18'sd16384, 18'sd16384, 18'sd49152};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send(vi[k], vq[k]);
            @(negedge clk);
            n_vec++;
            if ({bus.sym_out, bus.in_phs_dec, bus.quad_dec, bus.sym_valid} !== {es[k], ei[k], eq[k], 1'b1}) begin
                n_bad++;
                $display("FAIL tie_sat[%0d] got sym=%b i=%0d q=%0d v=%b exp %b %0d %0d 1",
                         k, bus.sym_out, bus.in_phs_dec, bus.quad_dec, bus.sym_valid, es[k], ei[k], eq[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic signed [17:0] vi [3] = '{18'sd32767, -18'sd1, 18'sd0};
        logic signed [17:0] vq [3] = '{-18'sd32767, 18'sd1, -18'sd131071};
        logic [3:0]         es [3] = '{4'b1101, 4'b0111, 4'b1100};
        logic signed [17:0] ei [3] = '{18'sd16384, -18'sd16384, 18'sd16384};
        logic signed [17:0] eq [3] = '{-18'sd16384, 18'sd16384, -18'sd49152};
        do_reset();
        // Strobes on three consecutive cycles; result k lands two negedges after strobe k
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                n_vec++;
                if ({bus.sym_out, bus.in_phs_dec, bus.quad_dec, bus.sym_valid} !== {es[c-2], ei[c-2], eq[c-2], 1'b1}) begin
                    n_bad++;
                    $display("FAIL b2b[%0d] got sym=%b i=%0d q=%0d v=%b exp %b %0d %0d 1",
                             c-2, bus.sym_out, bus.in_phs_dec, bus.quad_dec, bus.sym_valid, es[c-2], ei[c-2], eq[c-2]);
                end
            end else if (c == 5) begin
                n_vec++;
                if (bus.sym_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_tail got valid=%b exp 0", bus.sym_valid);
                end
            end
            if (c < 3) begin
                bus.sym_clk_en = 1'b1;
                bus.in_phs_in  = vi[c];
                bus.quad_in    = vq[c];
            end else begin
                drive_idle();
            end
        end
    endtask

    task automatic test_estimate;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send(18'sd20000, -18'sd20000);
            @(negedge clk);
            n_vec++;
            if ({bus.sym_out, bus.in_phs_dec, bus.quad_dec, bus.sym_valid} !== {4'b1101, 18'sd16384, -18'sd16384, 1'b1}) begin
                n_bad++;
                $display("FAIL est_sym[%0d] got sym=%b i=%0d q=%0d v=%b exp 1101 16384 -16384 1",
                         k, bus.sym_out, bus.in_phs_dec, bus.quad_dec, bus.sym_valid);
            end
            n_vec++;
            if ({bus.ref_update, bus.ref_level} !== {(k == 3), (k == 3) ? 18'sd20000 : 18'sd32768}) begin
                n_bad++;
                $display("FAIL est_ref[%0d] got upd=%b ref=%0d exp %b %0d",
                         k, bus.ref_update, bus.ref_level, (k == 3), (k == 3) ? 20000 : 32768);
            end
        end
        @(negedge clk);
        n_vec++;
        if (bus.ref_update !== 1'b0) begin
            n_bad++;
            $display("FAIL est_pulse got upd=%b exp 0", bus.ref_update);
        end
        send(18'sd20000, -18'sd20000);
        @(negedge clk);
        n_vec++;
        if ({bus.sym_out, bus.in_phs_dec, bus.quad_dec, bus.ref_update} !== {4'b1000, 18'sd30000, -18'sd30000, 1'b0}) begin
            n_bad++;
            $display("FAIL est_next got sym=%b i=%0d q=%0d upd=%b exp 1000 30000 -30000 0",
                     bus.sym_out, bus.in_phs_dec, bus.quad_dec, bus.ref_update);
        end
    endtask

    task automatic test_outer_saturation;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send(-18'sd131072, 18'sd131071);
            @(negedge clk);
            n_vec++;
            if ({bus.sym_out, bus.in_phs_dec, bus.quad_dec} !== {4'b0010, -18'sd49152, 18'sd49152}) begin
                n_bad++;
                $display("FAIL satfill[%0d] got sym=%b i=%0d q=%0d exp 0010 -49152 49152",
                         k, bus.sym_out, bus.in_phs_dec, bus.quad_dec);
            end
        end
        n_vec++;
        if (bus.ref_level !== 18'sd131071) begin
            n_bad++;
            $display("FAIL sat_ref got %0d exp 131071", bus.ref_level);
        end
        send(-18'sd131072, -18'sd131071);
        @(negedge clk);
        n_vec++;
        if ({bus.sym_out, bus.in_phs_dec, bus.quad_dec} !== {4'b0000, -18'sd131071, -18'sd131071}) begin
            n_bad++;
            $display("FAIL sat_outer got sym=%b i=%0d q=%0d exp 0000 -131071 -131071",
                     bus.sym_out, bus.in_phs_dec, bus.quad_dec);
        end
        send(18'sd65535, -18'sd1);
        @(negedge clk);
        n_vec++;
        if ({bus.sym_out, bus.in_phs_dec, bus.quad_dec} !== {4'b1101, 18'sd65535, -18'sd65535}) begin
            n_bad++;
            $display("FAIL sat_inner got sym=%b i=%0d q=%0d exp 1101 65535 -65535",
                     bus.sym_out, bus.in_phs_dec, bus.quad_dec);
        end
    endtask

    task automatic test_reset_mid_estimate;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            send(18'sd20000, 18'sd20000);
            @(negedge clk);
        end
        n_vec++;
        if (bus.ref_level !== 18'sd20000) begin
            n_bad++;
            $display("FAIL mid_pre got ref=%0d exp 20000", bus.ref_level);
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.ref_level, bus.sym_out, bus.ref_update} !== {18'sd32768, 4'b0000, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_rst got ref=%0d sym=%b upd=%b exp 32768 0000 0",
                     bus.ref_level, bus.sym_out, bus.ref_update);
        end
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(18'sd10000, 18'sd10000);
            @(negedge clk);
            n_vec++;
            if ({bus.sym_out, bus.in_phs_dec, bus.ref_update, bus.ref_level} !==
                {4'b1111, 18'sd16384, (k == 3), (k == 3) ? 18'sd10000 : 18'sd32768}) begin
                n_bad++;
                $display("FAIL mid_post[%0d] got sym=%b i=%0d upd=%b ref=%0d exp 1111 16384 %b %0d",
                         k, bus.sym_out, bus.in_phs_dec, bus.ref_update, bus.ref_level,
                         (k == 3), (k == 3) ? 10000 : 32768);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        test_reset();
        test_mapping();
        test_ties_and_sat();
        test_back_to_back();
        test_estimate();
        test_outer_saturation();
        test_reset_mid_estimate();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
